ddr4_lite_model: RTL and testbench
==================================

// Module: ddr4_lite_model
// PURPOSE
// - Synthesizable single-rank DDR4 x8 (2Gb org: 4 BG x 4 BA, 16K rows, 1K cols) memory model for sim/emulation benches.
// - Decodes DDR4 commands, tracks per-bank open rows, stores BL8 write data, returns read data at fixed latencies.
// - Data path is SDR-ized: each clk_p cycle carries two DDR beats, so a BL8 burst occupies 4 cycles.
// PARAMETERS
// - CL            11  read latency, clocks from RD command to first beat pair (>=2)
// - CWL           9   write latency, clocks from WR command to first beat pair (>=1)
// - MEM_ROW_BITS  2   low row bits kept in storage; depth = 2^(4+MEM_ROW_BITS+10) bytes, upper rows alias
// - ALERT_CYCLES  6   mem_alert_n low-pulse length on parity error
// PORTS
// - clk_p         in  1   clock; all sampling on rising edge
// - reset         in  1   async, active-high
// - model_enable  in  1   0: all commands ignored, outputs idle
// - cke           in  1   0: commands ignored (power-down not modelled)
// - cs_n,act_n,ras_n,cas_n,we_n  in 1 each  command pins
// - bg            in  2   bank group
// - ba            in  2   bank address
// - sa            in  14  address A13..A0 (A10 = AP/all-banks)
// - sa17          in  1   A17, parity only
// - par_in        in  1   command/address even parity
// - dq_wr         in  16  write beat pair: [7:0] even beat, [15:8] odd beat
// - dm_n_wr       in  2   per-beat data mask, active low (0 = byte not written)
// - dq_rd         out 16  read beat pair, same packing
// - dq_oe         out 1   1 while dq_rd carries burst data
// - mem_alert_n   out 1   active-low alert
// - prot_err      out 1   1-cycle pulse on protocol violation
// BEHAVIOUR
// - Reset: dq_rd=0, dq_oe=0, mem_alert_n=1, prot_err=0, all 16 banks idle, MR0..MR6=0, pipelines flushed; storage untouched.
// - Command valid at edge when cs_n=0, cke=1, model_enable=1. act_n=0: ACTIVATE, row=sa[13:0], bank={bg,ba}.
// - act_n=1, {ras_n,cas_n,we_n}: 000 MRS (MR[{bg[0],ba}]<=sa), 001 REF, 010 PRE (sa[10]=1 all banks), 011 RFU (ignored),
//   100 WR, 101 RD, 110 ZQ (no-op), 111 NOP.
// - ACT to open bank, RD/WR to idle bank, REF with any bank open, RD/WR within 4 clocks of previous RD/WR (tCCD):
//   command ignored, prot_err pulses next cycle. PRE of idle bank is legal no-op.
// - RD/WR column = {sa[9:3],3'b000} (sa[2:0] ignored); byte index = {bg,ba,row[MEM_ROW_BITS-1:0],col}.
// - sa[10]=1 on RD/WR: bank closes when command accepted; burst uses captured row.
// - WR at edge T: pair k (k=0..3) sampled at edge T+CWL+k, writes bytes col+2k (dq_wr[7:0]) and col+2k+1 ([15:8]) unless masked.
// - RD at edge T: dq_rd/dq_oe registered at edges T+CL+k (k=0..3) with bytes col+2k,col+2k+1 read from storage at that edge;
//   dq_oe drops at T+CL+4 unless a following burst continues seamlessly. dq_rd=0 when dq_oe=0.
// - Same-edge write beat and read fetch of one byte: read returns new data.
// - Reset mid-burst aborts both pipelines immediately; partially written bursts keep already-written beats.
// CONFIGURATION
// - PARITY_CHECK_EN defined: on a valid non-NOP/DES command, ^{act_n,ras_n,cas_n,we_n,bg,ba,sa17,sa} != par_in -> command
//   ignored, mem_alert_n low for ALERT_CYCLES clocks starting next edge (a new error restarts the count).
// - Not defined: par_in/sa17 ignored, mem_alert_n constant 1.
// TESTING
// - ACT bg=1 ba=2 row=0x0005; WR col=0x010 data pairs 0x1100,0x3322,0x5544,0x7766; RD same -> dq_oe 4 cycles at T+11, same data.
// - WR with dm_n_wr=2'b01 on pair 0 over prior 0xAAAA -> readback pair0=0xAA00 (odd beat kept), others updated.
// - RD to idle bank, ACT to open bank, REF with bank open, RD 2 clocks after RD -> prot_err=1 each, no data, state unchanged.
// - RD col=0x010 at T, RD col=0x018 at T+4 -> dq_oe continuous 8 cycles, bytes 0x10..0x1F in order.
// - PRE sa[10]=1 then RD bank 0 -> prot_err; MRS bg=0 ba=3 sa=0x0123 -> MR3=0x0123.
// - PARITY_CHECK_EN: ACT with wrong par_in -> mem_alert_n low exactly 6 cycles, bank stays idle; reset mid-pulse -> 1 at once.

Source files
------------

// File: rtl/ddr4_lite_model.sv
// Single-rank DDR4 x8 behavioural memory for benches: command decode, bank tracking, BL8 storage.
// Define PARITY_CHECK_EN to enable command/address parity checking and the mem_alert_n pulse.
module ddr4_lite_model #(
   parameter int unsigned CL           = 11,
   parameter int unsigned CWL          = 9,
   parameter int unsigned MEM_ROW_BITS = 2,
   parameter int unsigned ALERT_CYCLES = 6
) (
   input  logic        clk_p,
   input  logic        reset,
   input  logic        model_enable,
   input  logic        cke,
   input  logic        cs_n,
   input  logic        act_n,
   input  logic        ras_n,
   input  logic        cas_n,
   input  logic        we_n,
   input  logic [1:0]  bg,
   input  logic [1:0]  ba,
   input  logic [13:0] sa,
   input  logic        sa17,
   input  logic        par_in,
   input  logic [15:0] dq_wr,
   input  logic [1:0]  dm_n_wr,
   output logic [15:0] dq_rd,
   output logic        dq_oe,
   output logic        mem_alert_n,
   output logic        prot_err
);

   // Burst base = {bank, kept row bits, col[9:3]}; byte address appends {pair, beat}.
   localparam int unsigned BaseW = 4 + MEM_ROW_BITS + 7;
   localparam int unsigned AddrW = BaseW + 3;
   localparam int unsigned Depth = 2 ** AddrW;

   typedef struct packed {
      logic             valid;
      logic [BaseW-1:0] base;
   } burst_t;

   // ---------------------------------------------------------------- command decode
   logic       cmd_valid;
   logic       is_act, is_mrs, is_ref, is_pre, is_wr, is_rd, is_nop;
   logic [3:0] bank;

   assign cmd_valid = ~cs_n & cke & model_enable;
   assign bank      = {bg, ba};

   always_comb begin
      is_act = 1'b0;
      is_mrs = 1'b0;
      is_ref = 1'b0;
      is_pre = 1'b0;
      is_wr  = 1'b0;
      is_rd  = 1'b0;
      is_nop = 1'b0;
      if (cmd_valid) begin
         if (!act_n) begin
            is_act = 1'b1;
         end else begin
            unique case ({ras_n, cas_n, we_n})
               3'b000:  is_mrs = 1'b1;
               3'b001:  is_ref = 1'b1;
               3'b010:  is_pre = 1'b1;
               3'b100:  is_wr  = 1'b1;
               3'b101:  is_rd  = 1'b1;
               3'b111:  is_nop = 1'b1;
               default: ;
            endcase
         end
      end
   end

   logic par_err;
`ifdef PARITY_CHECK_EN
   assign par_err = cmd_valid & ~is_nop &
                    ((^{act_n, ras_n, cas_n, we_n, bg, ba, sa17, sa}) != par_in);
`else
   logic unused_par;
   assign par_err    = 1'b0;
   assign unused_par = par_in ^ sa17 ^ is_nop;
`endif

   // ---------------------------------------------------------------- bank state
   logic [15:0]             open_q;
   logic [MEM_ROW_BITS-1:0] row_q [16];
   logic [13:0]             mr_q [8];
   logic [1:0]              ccd_q;

   logic             ccd_busy, act_ok, rdwr_ok, err_d;
   logic [BaseW-1:0] cmd_base;

   assign ccd_busy = (ccd_q != 2'd0);
   assign act_ok   = is_act & ~par_err & ~open_q[bank];
   assign rdwr_ok  = (is_rd | is_wr) & ~par_err & open_q[bank] & ~ccd_busy;
   assign err_d    = ~par_err & ((is_act & open_q[bank]) |
                                 ((is_rd | is_wr) & (~open_q[bank] | ccd_busy)) |
                                 (is_ref & (|open_q)));
   assign cmd_base = {bank, row_q[bank], sa[9:3]};

   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         open_q   <= '0;
         ccd_q    <= 2'd0;
         prot_err <= 1'b0;
         for (int i = 0; i < 16; i++) row_q[i] <= '0;
         for (int i = 0; i < 8; i++) mr_q[i] <= '0;
      end else begin
         prot_err <= err_d;
         if (ccd_q != 2'd0) ccd_q <= ccd_q - 2'd1;
         if (act_ok) begin
            open_q[bank] <= 1'b1;
            row_q[bank]  <= sa[MEM_ROW_BITS-1:0];
         end
         if (rdwr_ok) begin
            // Next RD/WR is legal four clocks later, when ccd_q has counted down to zero.
            ccd_q <= 2'd3;
            if (sa[10]) open_q[bank] <= 1'b0;
         end
         if (is_pre && !par_err) begin
            if (sa[10]) open_q <= '0;
            else        open_q[bank] <= 1'b0;
         end
         if (is_mrs && !par_err) mr_q[{bg[0], ba}] <= sa;
      end
   end

   logic unused_mr;
   always_comb begin
      unused_mr = 1'b0;
      for (int i = 0; i < 8; i++) unused_mr = unused_mr ^ (^mr_q[i]);
   end

   // ---------------------------------------------------------------- burst pipelines
   burst_t           wr_dly_q [CWL];
   burst_t           rd_dly_q [CL];
   logic             wr_act_q, rd_act_q;
   logic [1:0]       wr_k_q, rd_k_q;
   logic [BaseW-1:0] wr_base_q, rd_base_q;

   logic             wr_now, rd_now;
   logic [1:0]       wr_k, rd_k;
   logic [BaseW-1:0] wr_base, rd_base;

   // A burst leaving the delay line takes priority so back-to-back bursts run seamlessly.
   always_comb begin
      wr_now  = 1'b0;
      wr_k    = wr_k_q;
      wr_base = wr_base_q;
      if (wr_dly_q[CWL-1].valid) begin
         wr_now  = 1'b1;
         wr_k    = 2'd0;
         wr_base = wr_dly_q[CWL-1].base;
      end else if (wr_act_q) begin
         wr_now = 1'b1;
      end
   end

   always_comb begin
      rd_now  = 1'b0;
      rd_k    = rd_k_q;
      rd_base = rd_base_q;
      if (rd_dly_q[CL-1].valid) begin
         rd_now  = 1'b1;
         rd_k    = 2'd0;
         rd_base = rd_dly_q[CL-1].base;
      end else if (rd_act_q) begin
         rd_now = 1'b1;
      end
   end

   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(CWL); i++) wr_dly_q[i] <= '0;
         for (int i = 0; i < int'(CL); i++) rd_dly_q[i] <= '0;
         wr_act_q  <= 1'b0;
         rd_act_q  <= 1'b0;
         wr_k_q    <= 2'd0;
         rd_k_q    <= 2'd0;
         wr_base_q <= '0;
         rd_base_q <= '0;
      end else begin
         wr_dly_q[0] <= '{valid: rdwr_ok & is_wr, base: cmd_base};
         rd_dly_q[0] <= '{valid: rdwr_ok & is_rd, base: cmd_base};
         for (int i = 1; i < int'(CWL); i++) wr_dly_q[i] <= wr_dly_q[i-1];
         for (int i = 1; i < int'(CL); i++) rd_dly_q[i] <= rd_dly_q[i-1];
         wr_act_q  <= wr_now & (wr_k != 2'd3);
         rd_act_q  <= rd_now & (rd_k != 2'd3);
         wr_k_q    <= wr_k + 2'd1;
         rd_k_q    <= rd_k + 2'd1;
         wr_base_q <= wr_base;
         rd_base_q <= rd_base;
      end
   end

   // ---------------------------------------------------------------- storage
   logic [7:0]       mem [Depth];
   logic [AddrW-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1;
   logic [15:0]      rd_data;

   assign wr_addr0 = {wr_base, wr_k, 1'b0};
   assign wr_addr1 = {wr_base, wr_k, 1'b1};
   assign rd_addr0 = {rd_base, rd_k, 1'b0};
   assign rd_addr1 = {rd_base, rd_k, 1'b1};

   // Storage is deliberately not reset so contents survive a model reset.
   always_ff @(posedge clk_p) begin
      if (wr_now) begin
         if (dm_n_wr[0]) mem[wr_addr0] <= dq_wr[7:0];
         if (dm_n_wr[1]) mem[wr_addr1] <= dq_wr[15:8];
      end
   end

   always_comb begin
      rd_data = {mem[rd_addr1], mem[rd_addr0]};
      if (wr_now && ({wr_base, wr_k} == {rd_base, rd_k})) begin
         if (dm_n_wr[0]) rd_data[7:0]  = dq_wr[7:0];
         if (dm_n_wr[1]) rd_data[15:8] = dq_wr[15:8];
      end
   end

   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         dq_oe <= 1'b0;
         dq_rd <= '0;
      end else begin
         dq_oe <= rd_now & model_enable;
         dq_rd <= (rd_now && model_enable) ? rd_data : 16'h0000;
      end
   end

   // ---------------------------------------------------------------- alert
`ifdef PARITY_CHECK_EN
   localparam int unsigned AlertW = $clog2(ALERT_CYCLES + 1);
   logic [AlertW-1:0] alert_cnt_q;

   always_ff @(posedge clk_p or posedge reset) begin
      if (reset) begin
         alert_cnt_q <= '0;
         mem_alert_n <= 1'b1;
      end else if (par_err) begin
         alert_cnt_q <= AlertW'(ALERT_CYCLES - 1);
         mem_alert_n <= 1'b0;
      end else if (alert_cnt_q != '0) begin
         alert_cnt_q <= alert_cnt_q - 1'b1;
         mem_alert_n <= 1'b0;
      end else begin
         mem_alert_n <= 1'b1;
      end
   end
`else
   assign mem_alert_n = 1'b1;
`endif

endmodule

// File: tb/tb_ddr4_lite_model.sv
// Directed bench for ddr4_lite_model: command table, data bursts, masking, tCCD, reset, parity.
module tb_ddr4_lite_model;

   localparam int unsigned CL  = 11;
   localparam int unsigned CWL = 9;

   localparam logic [3:0] CAct = 4'b0111;
   localparam logic [3:0] CMrs = 4'b1000;
   localparam logic [3:0] CRef = 4'b1001;
   localparam logic [3:0] CPre = 4'b1010;
   localparam logic [3:0] CRfu = 4'b1011;
   localparam logic [3:0] CWr  = 4'b1100;
   localparam logic [3:0] CRd  = 4'b1101;
   localparam logic [3:0] CZq  = 4'b1110;

   logic        clk_p = 1'b0;
   logic        reset, model_enable, cke, cs_n, act_n, ras_n, cas_n, we_n;
   logic [1:0]  bg, ba;
   logic [13:0] sa;
   logic        sa17, par_in;
   logic [15:0] dq_wr;
   logic [1:0]  dm_n_wr;
   logic [15:0] dq_rd;
   logic        dq_oe, mem_alert_n, prot_err;

   always #5 clk_p = ~clk_p;

   ddr4_lite_model #(
      .CL(CL), .CWL(CWL), .MEM_ROW_BITS(2), .ALERT_CYCLES(6)
   ) dut (
      .clk_p(clk_p), .reset(reset), .model_enable(model_enable), .cke(cke), .cs_n(cs_n),
      .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba), .sa(sa),
      .sa17(sa17), .par_in(par_in), .dq_wr(dq_wr), .dm_n_wr(dm_n_wr), .dq_rd(dq_rd),
      .dq_oe(dq_oe), .mem_alert_n(mem_alert_n), .prot_err(prot_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic        log_oe [4096];
   logic [15:0] log_rd [4096];
   logic        log_pe [4096];
   logic        log_al [4096];

   typedef struct packed {
      logic        en;
      logic [3:0]  c;
      logic [1:0]  g;
      logic [1:0]  b;
      logic [13:0] a;
      logic        exp_pe;
   } vec_t;

   localparam int NVec = 22;
   vec_t tbl [NVec];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Outputs registered at edge cyc are logged 1 ns after that edge.
   task automatic tick();
      @(posedge clk_p);
      #1;
      cyc++;
      log_oe[cyc] = dq_oe;
      log_rd[cyc] = dq_rd;
      log_pe[cyc] = prot_err;
      log_al[cyc] = mem_alert_n;
   endtask

   task automatic wait_until(input int x);
      while (cyc < x) tick();
   endtask

   task automatic cmd(input logic [3:0] c, input logic [1:0] g, input logic [1:0] b,
                      input logic [13:0] a, input logic bad_par, output int t);
      {act_n, ras_n, cas_n, we_n} = c;
      bg     = g;
      ba     = b;
      sa     = a;
      sa17   = 1'b0;
      par_in = (^{c, g, b, 1'b0, a}) ^ bad_par;
      cs_n   = 1'b0;
      tick();
      t    = cyc;
      cs_n = 1'b1;
      {act_n, ras_n, cas_n, we_n} = 4'b1111;
   endtask

   task automatic wr_burst(input logic [1:0] g, input logic [1:0] b, input logic [13:0] a,
                           input logic [3:0][15:0] d, input logic [3:0][1:0] m);
      int t;
      cmd(CWr, g, b, a, 1'b0, t);
      chk($sformatf("wr %h accepted", a), log_pe[t], 1'b0);
      for (int k = 0; k < 4; k++) begin
         wait_until(t + int'(CWL) + k - 1);
         dq_wr   = d[k];
         dm_n_wr = m[k];
         tick();
      end
      dq_wr   = '0;
      dm_n_wr = 2'b11;
   endtask

   task automatic rd_check(input string name, input logic [1:0] g, input logic [1:0] b,
                           input logic [13:0] a, input logic [3:0][15:0] e);
      int t;
      cmd(CRd, g, b, a, 1'b0, t);
      wait_until(t + int'(CL) + 5);
      chk({name, " accepted"}, log_pe[t], 1'b0);
      chk({name, " oe early"}, log_oe[t+CL-1], 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s oe%0d", name, k), log_oe[t+CL+k], 1'b1);
         chk($sformatf("%s pair%0d", name, k), log_rd[t+CL+k], e[k]);
      end
      chk({name, " oe end"}, log_oe[t+CL+4], 1'b0);
      chk({name, " rd end"}, log_rd[t+CL+4], 16'h0000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, t2;

      tbl[0]  = '{1'b1, CRd,  2'd0, 2'd0, 14'h0000, 1'b1};
      tbl[1]  = '{1'b1, CWr,  2'd0, 2'd1, 14'h0000, 1'b1};
      tbl[2]  = '{1'b1, CRef, 2'd0, 2'd0, 14'h0000, 1'b0};
      tbl[3]  = '{1'b1, CAct, 2'd0, 2'd0, 14'h0001, 1'b0};
      tbl[4]  = '{1'b1, CAct, 2'd0, 2'd0, 14'h0002, 1'b1};
      tbl[5]  = '{1'b1, CRef, 2'd0, 2'd0, 14'h0000, 1'b1};
      tbl[6]  = '{1'b1, CPre, 2'd1, 2'd1, 14'h0000, 1'b0};
      tbl[7]  = '{1'b1, CPre, 2'd0, 2'd0, 14'h0000, 1'b0};
      tbl[8]  = '{1'b1, CRd,  2'd0, 2'd0, 14'h0000, 1'b1};
      tbl[9]  = '{1'b0, CAct, 2'd2, 2'd1, 14'h0000, 1'b0};
      tbl[10] = '{1'b1, CAct, 2'd2, 2'd1, 14'h0000, 1'b0};
      tbl[11] = '{1'b1, CAct, 2'd0, 2'd0, 14'h0000, 1'b0};
      tbl[12] = '{1'b1, CAct, 2'd3, 2'd3, 14'h0000, 1'b0};
      tbl[13] = '{1'b1, CPre, 2'd1, 2'd0, 14'h0400, 1'b0};
      tbl[14] = '{1'b1, CRd,  2'd0, 2'd0, 14'h0000, 1'b1};
      tbl[15] = '{1'b1, CWr,  2'd3, 2'd3, 14'h0000, 1'b1};
      tbl[16] = '{1'b1, CAct, 2'd2, 2'd1, 14'h0000, 1'b0};
      tbl[17] = '{1'b1, CPre, 2'd2, 2'd1, 14'h0000, 1'b0};
      tbl[18] = '{1'b1, CMrs, 2'd0, 2'd3, 14'h0123, 1'b0};
      tbl[19] = '{1'b1, CZq,  2'd0, 2'd0, 14'h0000, 1'b0};
      tbl[20] = '{1'b1, CRfu, 2'd0, 2'd0, 14'h0000, 1'b0};
      tbl[21] = '{1'b1, CRef, 2'd0, 2'd0, 14'h0000, 1'b0};

      reset = 1'b1; model_enable = 1'b1; cke = 1'b1; cs_n = 1'b1;
      {act_n, ras_n, cas_n, we_n} = 4'b1111;
      bg = '0; ba = '0; sa = '0; sa17 = 1'b0; par_in = 1'b0;
      dq_wr = '0; dm_n_wr = 2'b11;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("reset dq_oe", dq_oe, 1'b0);
      chk("reset dq_rd", dq_rd, 16'h0000);
      chk("reset alert", mem_alert_n, 1'b1);
      chk("reset prot_err", prot_err, 1'b0);

      for (int i = 0; i < NVec; i++) begin
         model_enable = tbl[i].en;
         cmd(tbl[i].c, tbl[i].g, tbl[i].b, tbl[i].a, 1'b0, t);
         model_enable = 1'b1;
         tick();
         chk($sformatf("vec%0d prot", i), log_pe[t], tbl[i].exp_pe);
         chk($sformatf("vec%0d pulse", i), log_pe[t+1], 1'b0);
         chk($sformatf("vec%0d oe", i), log_oe[t+1], 1'b0);
      end
      chk("mr3", dut.mr_q[3], 14'h0123);

      // Basic write then read in bg1/ba2 row 5
      cmd(CAct, 2'd1, 2'd2, 14'h0005, 1'b0, t);
      chk("act b6", log_pe[t], 1'b0);
      wr_burst(2'd1, 2'd2, 14'h0010, {16'h7766, 16'h5544, 16'h3322, 16'h1100}, 8'hFF);
      rd_check("rd10", 2'd1, 2'd2, 14'h0010, {16'h7766, 16'h5544, 16'h3322, 16'h1100});

      // Seamless back-to-back reads
      wr_burst(2'd1, 2'd2, 14'h0018, {16'hFFEE, 16'hDDCC, 16'hBBAA, 16'h9988}, 8'hFF);
      cmd(CRd, 2'd1, 2'd2, 14'h0010, 1'b0, t);
      wait_until(t + 3);
      cmd(CRd, 2'd1, 2'd2, 14'h0018, 1'b0, t2);
      wait_until(t + int'(CL) + 9);
      chk("seam accept2", log_pe[t2], 1'b0);
      chk("seam early", log_oe[t+CL-1], 1'b0);
      for (int k = 0; k < 8; k++) begin
         logic [15:0] e;
         e = {4'(2*k + 1), 4'(2*k + 1), 4'(2*k), 4'(2*k)};
         chk($sformatf("seam oe%0d", k), log_oe[t+CL+k], 1'b1);
         chk($sformatf("seam pair%0d", k), log_rd[t+CL+k], e);
      end
      chk("seam end", log_oe[t+CL+8], 1'b0);

      // tCCD violation: second read two clocks later is dropped
      cmd(CRd, 2'd1, 2'd2, 14'h0010, 1'b0, t);
      wait_until(t + 1);
      cmd(CRd, 2'd1, 2'd2, 14'h0018, 1'b0, t2);
      wait_until(t + int'(CL) + 8);
      chk("ccd first ok", log_pe[t], 1'b0);
      chk("ccd prot", log_pe[t2], 1'b1);
      chk("ccd pair0", log_rd[t+CL], 16'h1100);
      chk("ccd pair3", log_rd[t+CL+3], 16'h7766);
      chk("ccd no 2nd", log_oe[t+CL+4], 1'b0);
      chk("ccd no 2nd late", log_oe[t+CL+6], 1'b0);

      // ACT to open bank leaves open row unchanged
      cmd(CAct, 2'd1, 2'd2, 14'h0006, 1'b0, t);
      chk("act open prot", log_pe[t], 1'b1);
      rd_check("rd keep row", 2'd1, 2'd2, 14'h0010, {16'h7766, 16'h5544, 16'h3322, 16'h1100});

      // Byte mask: odd beat of pair 0 keeps prior data
      wr_burst(2'd1, 2'd2, 14'h0020, {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA}, 8'hFF);
      wr_burst(2'd1, 2'd2, 14'h0020, {16'h9ABC, 16'h5678, 16'h1234, 16'hBB00}, 8'hFD);
      rd_check("rd mask", 2'd1, 2'd2, 14'h0020, {16'h9ABC, 16'h5678, 16'h1234, 16'hAA00});

      // Auto-precharge read: data from captured row, bank closed afterwards
      rd_check("rd ap", 2'd1, 2'd2, 14'h0417, {16'h7766, 16'h5544, 16'h3322, 16'h1100});
      cmd(CRd, 2'd1, 2'd2, 14'h0010, 1'b0, t);
      chk("rd after ap", log_pe[t], 1'b1);

      // Reset during an active read and a half-written burst
      cmd(CAct, 2'd1, 2'd2, 14'h0005, 1'b0, t);
      wr_burst(2'd1, 2'd2, 14'h0030, {16'h0404, 16'h0303, 16'h0202, 16'h0101}, 8'hFF);
      cmd(CRd, 2'd1, 2'd2, 14'h0010, 1'b0, t);
      wait_until(t + 3);
      cmd(CWr, 2'd1, 2'd2, 14'h0030, 1'b0, t2);
      wait_until(t2 + int'(CWL) - 1);
      dq_wr = 16'hA1A1;
      tick();
      dq_wr = 16'hB2B2;
      tick();
      chk("pre-reset oe", log_oe[cyc], 1'b1);
      chk("pre-reset rd", log_rd[cyc], 16'h7766);
      reset = 1'b1;
      #1;
      chk("mid reset oe", dq_oe, 1'b0);
      chk("mid reset rd", dq_rd, 16'h0000);
      dq_wr = 16'hC3C3;
      tick();
      tick();
      reset = 1'b0;
      dq_wr = 16'h0000;
      tick();
      chk("mr3 after reset", dut.mr_q[3], 14'h0000);
      cmd(CRd, 2'd1, 2'd2, 14'h0030, 1'b0, t);
      chk("bank idle after reset", log_pe[t], 1'b1);
      cmd(CAct, 2'd1, 2'd2, 14'h0005, 1'b0, t);
      rd_check("rd partial", 2'd1, 2'd2, 14'h0030, {16'h0404, 16'h0303, 16'hB2B2, 16'hA1A1});

`ifdef PARITY_CHECK_EN
      cmd(CAct, 2'd0, 2'd1, 14'h0003, 1'b1, t);
      wait_until(t + 8);
      chk("par before", log_al[t-1], 1'b1);
      for (int i = 0; i < 6; i++) chk($sformatf("par low%0d", i), log_al[t+i], 1'b0);
      chk("par end", log_al[t+6], 1'b1);
      chk("par no prot", log_pe[t], 1'b0);
      cmd(CRd, 2'd0, 2'd1, 14'h0010, 1'b0, t2);
      chk("par bank idle", log_pe[t2], 1'b1);
      cmd(CAct, 2'd0, 2'd1, 14'h0003, 1'b1, t);
      tick();
      chk("par pulse on", mem_alert_n, 1'b0);
      reset = 1'b1;
      #1;
      chk("par reset clears", mem_alert_n, 1'b1);
      tick();
      reset = 1'b0;
      tick();
`else
      cmd(CAct, 2'd0, 2'd1, 14'h0003, 1'b1, t);
      wait_until(t + 8);
      for (int i = 0; i < 8; i++) chk($sformatf("nopar alert%0d", i), log_al[t+i], 1'b1);
      chk("nopar accepted", log_pe[t], 1'b0);
      cmd(CAct, 2'd0, 2'd1, 14'h0003, 1'b0, t2);
      chk("nopar bank open", log_pe[t2], 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
